booth_seq_mult: RTL and testbench



---
 rtl/booth_seq_mult.sv | 112 +++++++++++
 tb/tb_booth_seq_mult.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, N steps per product.
// Optional macro BOOTH_ZERO_BYPASS_EN completes zero-operand products in a single cycle.
module booth_seq_mult #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N-1:0]        mcand,
  input  logic [N-1:0]        mplier,
  output logic                busy,
  output logic                done,
  output logic [2*N-1:0]      product
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [N:0]       r_a;
  logic [N:0]       r_m;
  logic [N-1:0]     r_q;
  logic             r_q1;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [2*N-1:0]   r_product;

  logic [N:0]       w_sum;
  logic [N:0]       w_a_next;
  logic [N-1:0]     w_q_next;
  logic             w_bypass;

  // A and M carry one guard bit so subtracting mcand = -2^(N-1) cannot overflow.
  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_q1})
      2'b01:   w_sum = r_a + r_m;
      2'b10:   w_sum = r_a - r_m;
      default: w_sum = r_a;
    endcase
  end

  assign w_a_next = {w_sum[N], w_sum[N:1]};
  assign w_q_next = {w_sum[0], r_q[N-1:1]};

`ifdef BOOTH_ZERO_BYPASS_EN
  assign w_bypass = (mcand == '0) || (mplier == '0);
`else
  assign w_bypass = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
          if (start) begin
            r_a   <= '0;
            r_q   <= mplier;
            r_q1  <= 1'b0;
            r_m   <= {mcand[N-1], mcand};
            r_cnt <= CW'(N);
            if (w_bypass) begin
              r_product <= '0;
              r_done    <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_a   <= w_a_next;
          r_q   <= w_q_next;
          r_q1  <= r_q[0];
          r_cnt <= r_cnt - CW'(1);
          // Last step: publish the low 2N bits of {A,Q} in one shot.
          if (r_cnt == CW'(1)) begin
            r_product <= {w_a_next[N-1:0], w_q_next};
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= DONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed bench for booth_seq_mult (N=8): expected products go through a scoreboard queue.
// Covers latency, ignored starts, back-to-back operation, mid-run reset and zero operands.
module tb_booth_seq_mult;

  localparam int N = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [N-1:0]      mcand;
  logic [N-1:0]      mplier;
  logic              busy;
  logic              done;
  logic [2*N-1:0]    product;

  logic [2*N-1:0]    sb[$];
  int                checks;
  int                failures;

  booth_seq_mult #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse at a negedge; the reference product comes from plain signed multiply.
  task automatic applyStimulus(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                               input bit expectResult);
    logic signed [2*N-1:0] e;
    e = a * b;
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    if (expectResult) sb.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    mcand  = $urandom_range(0, 255);
    mplier = $urandom_range(0, 255);
  endtask

  task automatic checkOutput(input string tag);
    logic [2*N-1:0] exp;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("[TB] FAIL %s: product=%0h but scoreboard empty", tag, product);
    end else begin
      exp = sb.pop_front();
      assert (product === exp) else begin
        failures++;
        $error("[TB] FAIL %s: product=%0h expected=%0h", tag, product, exp);
      end
    end
  endtask

  // Waits (bounded) for done; reports negedges waited and how many of them had busy high.
  task automatic waitDone(input string tag, output int waits, output int busyCnt);
    waits   = 0;
    busyCnt = 0;
    while (done !== 1'b1 && waits < 20) begin
      if (busy === 1'b1) busyCnt++;
      @(negedge clk);
      waits++;
    end
    checkVal({tag, "_doneSeen"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int waits;
    int busyCnt;
    int dones;
    int expLat;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    mcand    = '0;
    mplier   = '0;
`ifdef BOOTH_ZERO_BYPASS_EN
    expLat = 0;
`else
    expLat = N;
`endif

    repeat (3) @(negedge clk);
    checkVal("rst_busy", {31'd0, busy}, 32'd0);
    checkVal("rst_done", {31'd0, done}, 32'd0);
    checkVal("rst_product", {16'd0, product}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic 3*5 with latency");
    applyStimulus(3, 5, 1'b1);
    checkVal("b35_busyAfterAccept", {31'd0, busy}, 32'd1);
    waitDone("b35", waits, busyCnt);
    checkVal("b35_latency", waits, N);
    checkVal("b35_busyCycles", busyCnt, N);
    checkVal("b35_busyAtDone", {31'd0, busy}, 32'd0);
    checkOutput("b35_product");
    @(negedge clk);
    checkVal("b35_donePulseWidth", {31'd0, done}, 32'd0);
    checkVal("b35_productHeld", {16'd0, product}, 32'h000F);

    $display("[TB] signed corner operands");
    applyStimulus(-128, -128, 1'b1);
    waitDone("m128sq", waits, busyCnt);
    checkOutput("m128sq_product");
    @(negedge clk);
    applyStimulus(-7, 6, 1'b1);
    waitDone("m7x6", waits, busyCnt);
    checkOutput("m7x6_product");
    @(negedge clk);
    applyStimulus(127, -1, 1'b1);
    waitDone("p127xm1", waits, busyCnt);
    checkOutput("p127xm1_product");
    @(negedge clk);

    $display("[TB] start while busy is ignored");
    applyStimulus(3, 5, 1'b1);
    @(negedge clk);
    start  = 1'b1;
    mcand  = 8'd9;
    mplier = 8'd9;
    @(negedge clk);
    start  = 1'b0;
    waitDone("ign", waits, busyCnt);
    checkVal("ign_latency", waits, N - 2);
    checkOutput("ign_product");
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checkVal("ign_noSecondDone", dones, 0);
    checkVal("ign_idleBusy", {31'd0, busy}, 32'd0);

    $display("[TB] back-to-back operations");
    applyStimulus(3, 5, 1'b1);
    waitDone("b2b1", waits, busyCnt);
    checkOutput("b2b1_product");
    applyStimulus(2, -4, 1'b1);
    checkVal("b2b_doneDropped", {31'd0, done}, 32'd0);
    checkVal("b2b_busyRestarted", {31'd0, busy}, 32'd1);
    checkVal("b2b_productHeld", {16'd0, product}, 32'h000F);
    waitDone("b2b2", waits, busyCnt);
    checkVal("b2b2_latency", waits, N);
    checkOutput("b2b2_product");
    @(negedge clk);

    $display("[TB] reset mid-operation");
    applyStimulus(3, 5, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkVal("midrst_busy", {31'd0, busy}, 32'd0);
    checkVal("midrst_done", {31'd0, done}, 32'd0);
    checkVal("midrst_product", {16'd0, product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checkVal("midrst_noDone", dones, 0);
    applyStimulus(2, 2, 1'b1);
    waitDone("after_rst", waits, busyCnt);
    checkVal("after_rst_latency", waits, N);
    checkOutput("after_rst_product");
    @(negedge clk);

    $display("[TB] zero operand");
    applyStimulus(0, 55, 1'b1);
    waitDone("zero", waits, busyCnt);
    checkVal("zero_latency", waits, expLat);
    checkVal("zero_busyCycles", busyCnt, expLat);
    checkOutput("zero_product");
    @(negedge clk);
    checkVal("zero_donePulseWidth", {31'd0, done}, 32'd0);

    checkVal("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
